bch_seq_ctrl: RTL and testbench



---
 rtl/bch_seq_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_bch_seq_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bch_seq_ctrl.sv
// ---------------------------------------------------------------------------
// bch_seq_ctrl
//
// Top-level sequencer for the BCH decoder.  A decode request (code, mode) is
// latched in IDLE, codeword words are streamed into the LLR buffer, then the
// syndrome, Berlekamp-Massey and Chien engines are started one after another.
// In soft mode that engine sequence repeats once per test-pattern candidate
// and the lowest-metric successful candidate is kept.  The chosen result is
// then streamed out on finish/odata.  No GF arithmetic lives here.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   set, mode, code       decode request strobe, hard/soft select, code id
//   ready, word_we        word accept / LLR buffer write strobe (identical)
//   word_idx              index of the word being accepted
//   bch_t                 correction capability handed to BM
//   cand_idx              active candidate handed to the syndrome engine
//   synd/bm/chien_start   one-cycle engine start pulses
//   synd/bm/chien_done    one-cycle engine done strobes
//   chien_ok, err_cnt,
//   cand_metric           Chien result, valid with chien_done
//   rd_cand, rd_idx       result-store read select
//   err_loc               result-store read data (combinational)
//   finish, odata         output beat valid / error location or sentinel
//
// Optional feature macro: BCH_CTRL_TIMEOUT_EN adds a TIMEOUT_W-bit watchdog
// over the engine states; a stalled engine fails the current candidate.
// ---------------------------------------------------------------------------
module bch_seq_ctrl #(
    parameter int NUM_CAND  = 2,
    parameter int TIMEOUT_W = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set,
    input  logic       mode,
    input  logic [1:0] code,
    output logic       ready,
    output logic       word_we,
    output logic [6:0] word_idx,
    output logic [2:0] bch_t,
    output logic [1:0] cand_idx,
    output logic       synd_start,
    input  logic       synd_done,
    output logic       bm_start,
    input  logic       bm_done,
    output logic       chien_start,
    input  logic       chien_done,
    input  logic       chien_ok,
    input  logic [2:0] err_cnt,
    input  logic [9:0] cand_metric,
    output logic [1:0] rd_cand,
    output logic [1:0] rd_idx,
    input  logic [9:0] err_loc,
    output logic       finish,
    output logic [9:0] odata
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_SYND, S_BM, S_CHIEN, S_OUT
    } state_t;

    localparam logic [1:0] LAST_CAND = 2'(NUM_CAND - 1);

    state_t     state, state_nxt;
    logic       entry;        // first cycle of an engine state: start pulse cycle
    logic [1:0] code_reg;
    logic       mode_reg;
    logic [6:0] widx;
    logic [6:0] last_idx;
    logic [1:0] cand_reg;
    logic       best_valid;
    logic [1:0] best_cand;
    logic [2:0] best_cnt;
    logic [9:0] best_metric;
    logic [1:0] out_idx;

    logic in_engine, in_engine_nxt;
    logic done_acc, pass_ok, pass_end, take, last_beat;
    logic timeout;

    always_comb begin
        case (code_reg)
            2'd2:    last_idx = 7'd31;
            2'd3:    last_idx = 7'd127;
            default: last_idx = 7'd7;
        endcase
    end

    assign in_engine     = (state == S_SYND) || (state == S_BM) || (state == S_CHIEN);
    assign in_engine_nxt = (state_nxt == S_SYND) || (state_nxt == S_BM) || (state_nxt == S_CHIEN);

    // A done strobe counts only in the state that expects it, and never in
    // the same cycle as the start pulse.
    assign done_acc = !entry && (((state == S_SYND)  && synd_done) ||
                                 ((state == S_BM)    && bm_done)   ||
                                 ((state == S_CHIEN) && chien_done));
    assign pass_ok  = (state == S_CHIEN) && done_acc && chien_ok;
    assign pass_end = ((state == S_CHIEN) && done_acc) || timeout;
    // Strict compare: on a metric tie the earlier candidate stays.  In hard
    // mode best_valid is clear on the single pass, so take == pass_ok.
    assign take     = pass_ok && (!best_valid || (cand_metric < best_metric));
    assign last_beat = !best_valid || (best_cnt == 3'd0) ||
                       ({1'b0, out_idx} == (best_cnt - 3'd1));

`ifdef BCH_CTRL_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wdog;

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog <= '0;
        end else if (entry) begin
            wdog <= '0;
        end else if (in_engine && !(&wdog)) begin
            wdog <= wdog + 1'b1;
        end
    end

    // The stale count seen during the start cycle is not trusted.
    assign timeout = in_engine && !entry && (&wdog) && !done_acc;
`else
    // TIMEOUT_W only matters when the watchdog is built in.
    logic unused_timeout_w;
    assign unused_timeout_w = (TIMEOUT_W > 0);
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ready       = 1'b0;
        word_we     = 1'b0;
        word_idx    = widx;
        bch_t       = 3'd0;
        cand_idx    = cand_reg;
        synd_start  = 1'b0;
        bm_start    = 1'b0;
        chien_start = 1'b0;
        rd_cand     = 2'd0;
        rd_idx      = 2'd0;
        finish      = 1'b0;
        odata       = 10'd0;

        case (state)
            S_IDLE:  if (set && (code != 2'd0)) state_nxt = S_FETCH;
            S_FETCH: if (widx == last_idx) state_nxt = S_SYND;
            S_SYND:  if (done_acc) state_nxt = S_BM;
            S_BM:    if (done_acc) state_nxt = S_CHIEN;
            S_CHIEN: state_nxt = S_CHIEN;
            S_OUT:   if (last_beat) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (pass_end) begin
            state_nxt = (!mode_reg || (cand_reg >= LAST_CAND)) ? S_OUT : S_SYND;
        end

        if (state != S_IDLE) begin
            bch_t = (code_reg == 2'd3) ? 3'd4 : 3'd2;
        end
        ready       = (state == S_FETCH);
        word_we     = ready;
        synd_start  = (state == S_SYND)  && entry;
        bm_start    = (state == S_BM)    && entry;
        chien_start = (state == S_CHIEN) && entry;

        if (state == S_OUT) begin
            finish  = 1'b1;
            rd_cand = best_cand;
            rd_idx  = out_idx;
            if (!best_valid) begin
                odata = 10'd1022;
            end else if (best_cnt == 3'd0) begin
                odata = 10'd1023;
            end else begin
                odata = err_loc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry      <= 1'b0;
            code_reg   <= 2'd0;
            mode_reg   <= 1'b0;
            widx       <= 7'd0;
            cand_reg   <= 2'd0;
            best_valid <= 1'b0;
            out_idx    <= 2'd0;
        end else begin
            entry <= in_engine_nxt && (state_nxt != state);
            if ((state == S_IDLE) && set && (code != 2'd0)) begin
                code_reg <= code;
                mode_reg <= mode;
            end
            if (state == S_FETCH) begin
                widx <= (widx == last_idx) ? 7'd0 : widx + 7'd1;
            end
            if (take) begin
                best_valid <= 1'b1;
            end
            if (pass_end && mode_reg && (cand_reg < LAST_CAND)) begin
                cand_reg <= cand_reg + 2'd1;
            end
            if (state == S_OUT) begin
                if (last_beat) begin
                    out_idx    <= 2'd0;
                    cand_reg   <= 2'd0;
                    best_valid <= 1'b0;
                end else begin
                    out_idx <= out_idx + 2'd1;
                end
            end
        end
    end

    // Result payload only; qualified by best_valid, so no reset needed.
    always_ff @(posedge clk) begin
        if (take) begin
            best_cand   <= cand_reg;
            best_cnt    <= err_cnt;
            best_metric <= cand_metric;
        end
    end

endmodule

// File: tb/tb_bch_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bch_seq_ctrl
//
// Self-checking bench for bch_seq_ctrl.  A negedge engine model answers the
// start pulses after a programmable latency and records every observable
// event of a decode.  A directed table and randomized transactions are run;
// expected beats come from a plain best-candidate model, expected latency
// from the handoff rules.
// ---------------------------------------------------------------------------
module tb_bch_seq_ctrl;

    localparam int NUM_CAND = 2;

    logic       clk;
    logic       rst, set, mode;
    logic [1:0] code;
    logic       ready, word_we;
    logic [6:0] word_idx;
    logic [2:0] bch_t;
    logic [1:0] cand_idx;
    logic       synd_start, synd_done, bm_start, bm_done, chien_start, chien_done;
    logic       chien_ok;
    logic [2:0] err_cnt;
    logic [9:0] cand_metric;
    logic [1:0] rd_cand, rd_idx;
    logic [9:0] err_loc;
    logic       finish;
    logic [9:0] odata;

    typedef struct packed {
        logic [1:0]            code;
        logic                  mode;
        logic [3:0]            ok;
        logic [3:0][9:0]       metric;
        logic [3:0][2:0]       cnt;
        logic [3:0][3:0][9:0]  loc;
        logic [2:0]            lat;
        logic                  same;   // extra done in the start cycle
        logic                  stray;  // done strobes during FETCH
        logic                  setf;   // second set during FETCH
        logic [2:0]            exp_n;
        logic [3:0][9:0]       exp_data;
        logic [1:0]            exp_rdc;
    } vec_t;

    bch_seq_ctrl #(.NUM_CAND(NUM_CAND)) dut (
        .clk(clk), .rst(rst), .set(set), .mode(mode), .code(code),
        .ready(ready), .word_we(word_we), .word_idx(word_idx), .bch_t(bch_t),
        .cand_idx(cand_idx), .synd_start(synd_start), .synd_done(synd_done),
        .bm_start(bm_start), .bm_done(bm_done), .chien_start(chien_start),
        .chien_done(chien_done), .chien_ok(chien_ok), .err_cnt(err_cnt),
        .cand_metric(cand_metric), .rd_cand(rd_cand), .rd_idx(rd_idx),
        .err_loc(err_loc), .finish(finish), .odata(odata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t cur = '0;
    int   lat = 3;
    bit   same = 1'b0, stray = 1'b0, hold_bm = 1'b0;
    int   txn_id = 0;

    always_comb err_loc = cur.loc[rd_cand][rd_idx];

    // Engine model / event recorder
    int cyc = 0, seen_id = -1, done_id = -1;
    int n_ready, n_synd, n_bm, n_chien, idx_err, seq_err, dbl;
    int c_set, c_fin, nbeats, post_cand;
    int s_cd, b_cd, c_cd;
    int beats[8];
    int rdcs[8];
    bit set_seen, fin_seen;
    logic prev_s = 1'b0, prev_b = 1'b0, prev_c = 1'b0;

    initial begin
        synd_done = 1'b0; bm_done = 1'b0; chien_done = 1'b0;
        chien_ok = 1'b0; err_cnt = 3'd0; cand_metric = 10'd0;
        forever begin
            @(negedge clk);
            cyc++;
            if (txn_id != seen_id) begin
                seen_id = txn_id;
                n_ready = 0; n_synd = 0; n_bm = 0; n_chien = 0;
                idx_err = 0; seq_err = 0; dbl = 0; nbeats = 0;
                c_set = 0; c_fin = 0; post_cand = -1;
                s_cd = 0; b_cd = 0; c_cd = 0;
                set_seen = 1'b0; fin_seen = 1'b0;
            end
            synd_done = 1'b0; bm_done = 1'b0; chien_done = 1'b0;
            if (!set_seen && set && (code != 2'd0) && !rst) begin
                set_seen = 1'b1;
                c_set = cyc;
            end
            if (ready) begin
                if (word_we !== 1'b1 || word_idx != 7'(n_ready)) idx_err++;
                n_ready++;
            end
            if (synd_start) begin
                if (prev_s) dbl++;
                if (int'(cand_idx) != n_synd || int'(bch_t) != ((cur.code == 2'd3) ? 4 : 2))
                    seq_err++;
                n_synd++;
                s_cd = lat;
                if (same) synd_done = 1'b1;
            end else if (s_cd > 0) begin
                s_cd--;
                if (s_cd == 0) synd_done = 1'b1;
            end
            if (bm_start) begin
                if (prev_b) dbl++;
                n_bm++;
                b_cd = hold_bm ? 0 : lat;
                if (same && !hold_bm) bm_done = 1'b1;
            end else if (b_cd > 0) begin
                b_cd--;
                if (b_cd == 0) bm_done = 1'b1;
            end
            if (chien_start) begin
                if (prev_c) dbl++;
                n_chien++;
                c_cd = lat;
                if (same) chien_done = 1'b1;
            end else if (c_cd > 0) begin
                c_cd--;
                if (c_cd == 0) chien_done = 1'b1;
            end
            if (stray && ready && word_idx == 7'd2) begin
                synd_done = 1'b1; bm_done = 1'b1; chien_done = 1'b1;
            end
            prev_s = synd_start; prev_b = bm_start; prev_c = chien_start;
            if (chien_done) begin
                chien_ok    = cur.ok[cand_idx];
                err_cnt     = cur.cnt[cand_idx];
                cand_metric = cur.metric[cand_idx];
            end else begin
                chien_ok    = 1'($urandom);
                err_cnt     = 3'($urandom);
                cand_metric = 10'($urandom);
            end
            if (finish) begin
                if (!fin_seen) c_fin = cyc;
                fin_seen = 1'b1;
                if (nbeats < 8) begin
                    beats[nbeats] = int'(odata);
                    rdcs[nbeats]  = int'(rd_cand);
                end
                nbeats++;
            end else if (fin_seen && done_id != seen_id) begin
                done_id   = seen_id;
                post_cand = int'(cand_idx);
            end
        end
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        outs = {ready, word_we, word_idx, bch_t, cand_idx, synd_start, bm_start,
                chien_start, rd_cand, rd_idx, finish, odata};
    endfunction

    // Best candidate = lowest metric among successful passes, earliest on tie.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int best, np;
        r = v;
        best = -1;
        np = v.mode ? NUM_CAND : 1;
        for (int c = 0; c < np; c++)
            if (v.ok[c] && (best < 0 || v.metric[c] < v.metric[best])) best = c;
        r.exp_data = '0;
        r.exp_rdc  = 2'd0;
        if (best < 0) begin
            r.exp_n = 3'd1;
            r.exp_data[0] = 10'd1022;
        end else if (v.cnt[best] == 3'd0) begin
            r.exp_n = 3'd1;
            r.exp_data[0] = 10'd1023;
        end else begin
            r.exp_n = v.cnt[best];
            r.exp_rdc = 2'(best);
            for (int i = 0; i < int'(v.cnt[best]); i++) r.exp_data[i] = v.loc[best][i];
        end
        return r;
    endfunction

    task automatic run_decode(input vec_t v, input string tag);
        int nw, np, budget;
        nw = (v.code == 2'd3) ? 128 : (v.code == 2'd2) ? 32 : 8;
        np = v.mode ? NUM_CAND : 1;
        cur = v; lat = int'(v.lat); same = v.same; stray = v.stray;
        txn_id++;
        @(posedge clk); #1;
        set = 1'b1; code = v.code; mode = v.mode;
        @(posedge clk); #1;
        set = 1'b0; code = 2'd0; mode = 1'b0;
        if (v.setf) begin
            @(posedge clk); #1;
            set = 1'b1; code = 2'd3; mode = ~v.mode;
            @(posedge clk); #1;
            set = 1'b0; code = 2'd0; mode = 1'b0;
        end
        budget = hold_bm ? 6000 : 2000;
        for (int i = 0; i < budget && done_id != txn_id; i++) @(posedge clk);
        chk({tag, "_complete"}, (done_id == txn_id) ? 1 : 0, 1);
        chk({tag, "_ready_beats"}, n_ready, nw);
        chk({tag, "_word_idx_errs"}, idx_err, 0);
        chk({tag, "_synd_starts"}, n_synd, np);
        chk({tag, "_bm_starts"}, n_bm, np);
        chk({tag, "_chien_starts"}, n_chien, hold_bm ? 0 : np);
        chk({tag, "_cand_bcht_errs"}, seq_err, 0);
        chk({tag, "_wide_pulses"}, dbl, 0);
        chk({tag, "_finish_beats"}, nbeats, int'(v.exp_n));
        for (int i = 0; i < int'(v.exp_n) && i < 8; i++) begin
            chk($sformatf("%s_odata%0d", tag, i), beats[i], int'(v.exp_data[i]));
            if (v.exp_data[i] < 10'd1022)
                chk($sformatf("%s_rd_cand%0d", tag, i), rdcs[i], int'(v.exp_rdc));
        end
        if (!hold_bm)
            chk({tag, "_latency"}, c_fin - c_set, 1 + nw + np * 3 * (int'(v.lat) + 1));
        chk({tag, "_cand_idx_after"}, post_cand, 0);
    endtask

    vec_t vecs[6];
    vec_t v;
    int   snap, bad;

    initial begin
        rst = 1'b1; set = 1'b0; mode = 1'b0; code = 2'd0;

        for (int i = 0; i < 6; i++) vecs[i] = '0;
        // hard code1: two errors at 5, 40
        vecs[0].code = 2'd1; vecs[0].ok = 4'b0001; vecs[0].cnt[0] = 3'd2;
        vecs[0].loc[0][0] = 10'd5; vecs[0].loc[0][1] = 10'd40; vecs[0].lat = 3'd3;
        vecs[0].exp_n = 3'd2; vecs[0].exp_data[0] = 10'd5; vecs[0].exp_data[1] = 10'd40;
        // hard code3, no errors, second set during fetch
        vecs[1].code = 2'd3; vecs[1].ok = 4'b0001; vecs[1].lat = 3'd2; vecs[1].setf = 1'b1;
        vecs[1].exp_n = 3'd1; vecs[1].exp_data[0] = 10'd1023;
        // soft: cand1 wins on metric, done also pulsed in start cycles
        vecs[2].code = 2'd1; vecs[2].mode = 1'b1; vecs[2].ok = 4'b0011;
        vecs[2].metric[0] = 10'd30; vecs[2].cnt[0] = 3'd1; vecs[2].loc[0][0] = 10'd17;
        vecs[2].metric[1] = 10'd12; vecs[2].cnt[1] = 3'd2;
        vecs[2].loc[1][0] = 10'd3; vecs[2].loc[1][1] = 10'd9; vecs[2].lat = 3'd3; vecs[2].same = 1'b1;
        vecs[2].exp_n = 3'd2; vecs[2].exp_data[0] = 10'd3; vecs[2].exp_data[1] = 10'd9;
        vecs[2].exp_rdc = 2'd1;
        // soft: both candidates fail, stray dones during fetch
        vecs[3].code = 2'd2; vecs[3].mode = 1'b1; vecs[3].ok = 4'b0000; vecs[3].lat = 3'd1;
        vecs[3].stray = 1'b1; vecs[3].cnt[0] = 3'd3; vecs[3].cnt[1] = 3'd2;
        vecs[3].exp_n = 3'd1; vecs[3].exp_data[0] = 10'd1022;
        // soft: metric tie keeps cand0
        vecs[4].code = 2'd1; vecs[4].mode = 1'b1; vecs[4].ok = 4'b0011;
        vecs[4].metric[0] = 10'd20; vecs[4].cnt[0] = 3'd1; vecs[4].loc[0][0] = 10'd11;
        vecs[4].metric[1] = 10'd20; vecs[4].cnt[1] = 3'd1; vecs[4].loc[1][0] = 10'd22;
        vecs[4].lat = 3'd2;
        vecs[4].exp_n = 3'd1; vecs[4].exp_data[0] = 10'd11; vecs[4].exp_rdc = 2'd0;
        // hard fail
        vecs[5].code = 2'd2; vecs[5].ok = 4'b1110; vecs[5].cnt[0] = 3'd2; vecs[5].lat = 3'd4;
        vecs[5].exp_n = 3'd1; vecs[5].exp_data[0] = 10'd1022;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", int'(outs()), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_after_reset", int'(outs()), 0);

        set = 1'b1; code = 2'd0; mode = 1'b1;
        @(posedge clk); #1;
        set = 1'b0; mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("code0_ignored", int'(outs()), 0);

        for (int i = 0; i < 6; i++) run_decode(vecs[i], $sformatf("dir%0d", i));

        for (int t = 0; t < 16; t++) begin
            v = '0;
            v.code = 2'($urandom_range(1, 3));
            v.mode = 1'($urandom);
            v.ok   = 4'($urandom);
            for (int c = 0; c < 4; c++) begin
                v.metric[c] = 10'($urandom_range(0, 3));
                v.cnt[c]    = 3'($urandom_range(0, 4));
                for (int j = 0; j < 4; j++) v.loc[c][j] = 10'($urandom_range(0, 1021));
            end
            v.lat   = 3'($urandom_range(1, 4));
            v.same  = 1'($urandom);
            v.stray = 1'($urandom);
            v.setf  = 1'($urandom);
            run_decode(model(v), $sformatf("rnd%0d", t));
        end

        // reset while BM is running
        cur = vecs[2]; lat = 4; same = 1'b0; stray = 1'b0;
        txn_id++;
        @(posedge clk); #1;
        set = 1'b1; code = 2'd1; mode = 1'b1;
        @(posedge clk); #1;
        set = 1'b0; code = 2'd0; mode = 1'b0;
        for (int i = 0; i < 500 && n_bm == 0; i++) @(posedge clk);
        chk("bm_reached", (n_bm > 0) ? 1 : 0, 1);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_bm_outputs", int'(outs()), 0);
        rst = 1'b0;
        snap = n_synd + n_bm + n_chien;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (outs() != 32'd0) bad++;
        end
        chk("post_rst_quiet", bad, 0);
        chk("post_rst_no_starts", n_synd + n_bm + n_chien - snap, 0);

        run_decode(vecs[0], "after_rst");

`ifdef BCH_CTRL_TIMEOUT_EN
        v = '0;
        v.code = 2'd1; v.ok = 4'b1111; v.cnt[0] = 3'd1; v.lat = 3'd2;
        v.exp_n = 3'd1; v.exp_data[0] = 10'd1022;
        hold_bm = 1'b1;
        run_decode(v, "timeout");
        hold_bm = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
